// File: rtl/median_window_filter_if.sv
// Sample/result bus of the sliding-window median filter.
//
// Handshake: data_rdy is a one-cycle strobe qualified by the filter's
// internal IDLE state; a strobe seen while busy=1 is dropped and latches
// overrun. data_vld is a one-cycle pulse marking a freshly registered
// result. There is no backpressure from the consumer. flush is a
// synchronous clear that wins over data_rdy.
interface median_window_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_rdy;
  logic [1:0]            sel;
  logic                  flush;
  logic [DATA_WIDTH-1:0] result;
  logic                  data_vld;
  logic                  busy;
  logic                  full;
  logic                  overrun;

  modport master (
    output data_in, data_rdy, sel, flush,
    input  result, data_vld, busy, full, overrun
  );

  modport slave (
    input  data_in, data_rdy, sel, flush,
    output result, data_vld, busy, full, overrun
  );
endinterface

// File: rtl/median_window_filter.sv
// Sliding-window order-statistic filter: keeps the last WINDOW samples in
// arrival order plus an ascending sorted copy, and reports median/min/max
// of the window once it is full. Each sample takes IDLE->UPDATE->EMIT.
module median_window_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  median_window_filter_if.slave bus,
  output logic [1:0]           state_o   // debug: 0 IDLE, 1 UPDATE, 2 EMIT
);
  localparam int PW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CW  = $clog2(WINDOW + 1);
  localparam int MID = WINDOW / 2;
  localparam logic [PW-1:0] PTR_LAST = PW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] ring_q   [WINDOW];
  logic [DATA_WIDTH-1:0] sorted_q [WINDOW];
  logic [DATA_WIDTH-1:0] sorted_d [WINDOW];
  logic [DATA_WIDTH-1:0] tmp      [WINDOW-1];
  logic [DATA_WIDTH-1:0] sample_q;
  logic [DATA_WIDTH-1:0] oldest;
  logic [DATA_WIDTH-1:0] stat_d;
  logic [DATA_WIDTH-1:0] result_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  full_q;
  logic                  overrun_q;
  logic                  vld_q;
  logic                  busy_q;
  logic                  found;
  int                    rem_idx;
  int                    ins_pos;
  int                    n_valid;

  // Next sorted array: drop one copy of the oldest sample (only when full),
  // then insert the new sample at its ascending position.
  always_comb begin
    oldest  = ring_q[wr_ptr_q];
    found   = 1'b0;
    rem_idx = WINDOW - 1;
    for (int i = 0; i < WINDOW; i++) begin
      if (!found && sorted_q[i] == oldest) begin
        found   = 1'b1;
        rem_idx = i;
      end
    end
    n_valid = full_q ? WINDOW - 1 : int'(count_q);
    for (int i = 0; i < WINDOW - 1; i++) begin
      tmp[i] = (full_q && i >= rem_idx) ? sorted_q[i+1] : sorted_q[i];
    end
    ins_pos = 0;
    for (int i = 0; i < WINDOW - 1; i++) begin
      if (i < n_valid && tmp[i] < sample_q) ins_pos = ins_pos + 1;
    end
    for (int i = 0; i < WINDOW; i++) begin
      if (i < ins_pos)       sorted_d[i] = tmp[(i < WINDOW - 1) ? i : WINDOW - 2];
      else if (i == ins_pos) sorted_d[i] = sample_q;
      else                   sorted_d[i] = tmp[(i > 0) ? i - 1 : 0];
    end
  end

  // Statistic selected by sel; 11 aliases median.
  always_comb begin
    case (bus.sel)
      2'b01:   stat_d = sorted_q[0];
      2'b10:   stat_d = sorted_q[WINDOW-1];
      default: stat_d = sorted_q[MID];
    endcase
  end

  // Sample storage: contents need no reset, only the fill count qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (state_q == IDLE && bus.data_rdy) sample_q <= bus.data_in;
      if (state_q == UPDATE) begin
        ring_q[wr_ptr_q] <= sample_q;
        sorted_q         <= sorted_d;
      end
    end
  end

  // Control FSM with registered status outputs; rst beats flush beats data_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      result_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
    end else if (bus.flush) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      count_q   <= '0;
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
    end else begin
      vld_q <= 1'b0;
      if (state_q != IDLE && bus.data_rdy) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.data_rdy) begin
            state_q <= UPDATE;
            busy_q  <= 1'b1;
          end
        end
        UPDATE: begin
          wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
          if (!full_q) begin
            count_q <= count_q + 1'b1;
            full_q  <= (count_q == CNT_LAST);
          end
          state_q <= EMIT;
        end
        EMIT: begin
          if (full_q) begin
            vld_q    <= 1'b1;
            result_q <= stat_d;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.data_vld = vld_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
  assign bus.overrun  = overrun_q;
  assign state_o      = state_q;
endmodule
